// File: rtl/sqrt_recon_seq_pkg.sv
// Shared definitions for the integer square-root wrapper and its round-trip checker.
package sqrt_pkg;

    localparam int Q_WIDTH = 8;
    localparam int R_WIDTH = Q_WIDTH + 1;
    localparam int WIDTH   = 16;
    localparam int ACC_W   = 2 * Q_WIDTH + 1;

    // Sequencer states for the iterative reconstruction.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;

    // Counter width for a 0..qWidth-1 bit index; never narrower than one bit.
    function automatic int cnt_width(input int qWidth);
        int w;
        w = $clog2(qWidth);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CNT_W = cnt_width(Q_WIDTH);

endpackage

// File: rtl/sqrt_recon_seq_if.sv
// Operand/result handshake bundle between the sqrt output and the reconstruction block.
interface sqrt_recon_seq_if #(
    parameter int Q_WIDTH = 8,
    parameter int R_WIDTH = 9,
    parameter int WIDTH   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [Q_WIDTH-1:0] q_in;
    logic [R_WIDTH-1:0] rem_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   radical;
    logic               ovf;
    logic               rem_err;

    modport master (
        output in_valid, q_in, rem_in, out_ready,
        input  in_ready, out_valid, radical, ovf, rem_err
    );

    modport slave (
        input  in_valid, q_in, rem_in, out_ready,
        output in_ready, out_valid, radical, ovf, rem_err
    );
endinterface

// File: rtl/sqrt_recon_seq_step.sv
// One shift-add multiply step: conditionally add the multiplicand, then shift both operands.
module shift_add_mul_step #(
    parameter int Q_WIDTH = 8
) (
    input  logic [2*Q_WIDTH-1:0] mcand_i,
    input  logic [Q_WIDTH-1:0]   mplier_i,
    input  logic [2*Q_WIDTH:0]   acc_i,
    output logic [2*Q_WIDTH-1:0] mcand_o,
    output logic [Q_WIDTH-1:0]   mplier_o,
    output logic [2*Q_WIDTH:0]   acc_o
);

    // Add the partial product for the current multiplier bit and advance to the next bit.
    always_comb begin
        acc_o    = acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
        if (mplier_i[0]) begin
            acc_o = acc_i + {1'b0, mcand_i};
        end
    end

endmodule

// File: rtl/sqrt_recon_seq.sv
// Rebuilds radical = q*q + remainder with a one-bit-per-clock shift-add multiplier.
module sqrt_recon_seq
    import sqrt_pkg::*;
#(
    parameter int Q_WIDTH = sqrt_pkg::Q_WIDTH,
    parameter int R_WIDTH = sqrt_pkg::R_WIDTH,
    parameter int WIDTH   = sqrt_pkg::WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    sqrt_recon_seq_if.slave   bus
);

    localparam int LACC_W = 2 * Q_WIDTH + 1;
    localparam int LCNT_W = cnt_width(Q_WIDTH);
    localparam logic [LCNT_W-1:0] LAST_CNT = LCNT_W'(Q_WIDTH - 1);

    sqrt_state_t          state_q, state_d;
    logic [2*Q_WIDTH-1:0] mcand_q, mcand_d;
    logic [Q_WIDTH-1:0]   mplier_q, mplier_d;
    logic [LACC_W-1:0]    acc_q, acc_d;
    logic [LCNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]     radical_q, radical_d;
    logic                 ovf_q, ovf_d;
    logic                 remErr_q, remErr_d;

    logic [2*Q_WIDTH-1:0] stepMcand;
    logic [Q_WIDTH-1:0]   stepMplier;
    logic [LACC_W-1:0]    stepAcc;
    logic [R_WIDTH:0]     remWide;
    logic [R_WIDTH:0]     twoQ;

    shift_add_mul_step #(
        .Q_WIDTH (Q_WIDTH)
    ) u_step (
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_i    (acc_q),
        .mcand_o  (stepMcand),
        .mplier_o (stepMplier),
        .acc_o    (stepAcc)
    );

    // Legality test for the incoming pair, compared one bit wider so 2*q cannot wrap.
    always_comb begin
        remWide = {1'b0, bus.rem_in};
        twoQ    = (R_WIDTH + 1)'({bus.q_in, 1'b0});
    end

    // Next-state, datapath update and handshake outputs for the three-state sequencer.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        radical_d = radical_q;
        ovf_d     = ovf_q;
        remErr_d  = remErr_q;

        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    mcand_d  = (2 * Q_WIDTH)'(bus.q_in);
                    mplier_d = bus.q_in;
                    acc_d    = LACC_W'(bus.rem_in);
                    cnt_d    = '0;
                    remErr_d = (remWide > twoQ);
                    state_d  = CALC;
                end
            end
            CALC: begin
                mcand_d  = stepMcand;
                mplier_d = stepMplier;
                acc_d    = stepAcc;
                cnt_d    = cnt_q + LCNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    radical_d = stepAcc[WIDTH-1:0];
                    ovf_d     = |(stepAcc >> WIDTH);
                    state_d   = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            radical_q <= '0;
            ovf_q     <= 1'b0;
            remErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            radical_q <= radical_d;
            ovf_q     <= ovf_d;
            remErr_q  <= remErr_d;
        end
    end

    assign bus.radical = radical_q;
    assign bus.ovf     = ovf_q;
    assign bus.rem_err = remErr_q;

endmodule

// File: tb/tb_sqrt_recon_seq.sv
// Self-checking bench for sqrt_recon_seq: directed vectors plus a transaction-level model.
module tb_sqrt_recon_seq;

    localparam int QW  = 8;
    localparam int LAT = QW;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sqrt_recon_seq_if #(.Q_WIDTH(8), .R_WIDTH(9), .WIDTH(16)) bif ();

    sqrt_recon_seq #(.Q_WIDTH(8), .R_WIDTH(9), .WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: busy flag, accept cycle and the expected result.
    int          cyc;
    int          acceptCyc;
    bit          busy;
    logic [15:0] expRad;
    logic        expOvf;
    logic        expErr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc  = 0;
            busy = 1'b0;
        end else begin
            cyc++;
            if (busy) begin
                if ((cyc - 1 - acceptCyc) >= LAT && bif.out_ready) begin
                    busy = 1'b0;
                end
            end else if (bif.in_valid) begin
                int full;
                full      = int'(bif.q_in) * int'(bif.q_in) + int'(bif.rem_in);
                expRad    = full[15:0];
                expOvf    = (full > 65535);
                expErr    = (int'(bif.rem_in) > 2 * int'(bif.q_in));
                acceptCyc = cyc;
                busy      = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic expValid;
            expValid = busy && ((cyc - acceptCyc) >= LAT);
            check("model in_ready", bif.in_ready, !busy);
            check("model out_valid", bif.out_valid, expValid);
            if (expValid) begin
                check("model radical", bif.radical, expRad);
                check("model ovf", bif.ovf, expOvf);
                check("model rem_err", bif.rem_err, expErr);
            end
        end
    end

    // Present one operand pair and hold it until the block takes it.
    task automatic applyStimulus(input logic [7:0] q, input logic [8:0] r);
        bit got;
        got = 0;
        bif.q_in     = q;
        bif.rem_in   = r;
        bif.in_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bif.in_ready) got = 1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: got no in_ready expected in_ready=1");
        end
        @(posedge clk);
        #2;
        bif.in_valid = 1'b0;
    endtask

    // Wait for a result, compare to literal expectations, then let the handshake complete.
    task automatic checkOutput(input string name, input logic [15:0] rad,
                               input logic ovf, input logic err);
        bit got;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bif.out_valid) got = 1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: got out_valid=0 expected 1", name);
        end else begin
            check({name, " radical"}, bif.radical, rad);
            check({name, " ovf"}, bif.ovf, ovf);
            check({name, " rem_err"}, bif.rem_err, err);
        end
        while (!bif.out_ready) @(posedge clk);
        @(posedge clk);
        #2;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bif.in_valid = 1'b0;
        bif.q_in     = '0;
        bif.rem_in   = '0;
        bif.out_ready = 1'b1;

        // Reset values.
        repeat (2) @(negedge clk);
        check("reset in_ready", bif.in_ready, 1);
        check("reset out_valid", bif.out_valid, 0);
        check("reset radical", bif.radical, 0);
        check("reset ovf", bif.ovf, 0);
        check("reset rem_err", bif.rem_err, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        applyStimulus(8'd0, 9'd0);
        checkOutput("zero", 16'd0, 1'b0, 1'b0);
        applyStimulus(8'd12, 9'd5);
        checkOutput("q12r5", 16'd149, 1'b0, 1'b0);
        applyStimulus(8'd255, 9'd510);
        checkOutput("max legal", 16'd65535, 1'b0, 1'b0);
        applyStimulus(8'd255, 9'd511);
        checkOutput("overflow", 16'd0, 1'b1, 1'b1);
        applyStimulus(8'd3, 9'd7);
        checkOutput("q3r7", 16'd16, 1'b0, 1'b1);

        // Backpressure with a stray in_valid pulse while the result is held.
        bif.out_ready = 1'b0;
        applyStimulus(8'd10, 9'd4);
        for (int i = 0; i < 20 && !bif.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            bif.in_valid = (i == 2);
            bif.q_in     = 8'd1;
            bif.rem_in   = 9'd0;
            @(negedge clk);
            check("hold out_valid", bif.out_valid, 1);
            check("hold radical", bif.radical, 104);
            check("hold in_ready", bif.in_ready, 0);
        end
        @(posedge clk);
        #2;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no stray result", bif.out_valid, 0);
        end

        // Reset during CALC aborts the operation.
        applyStimulus(8'd200, 9'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort in_ready", bif.in_ready, 1);
        check("abort out_valid", bif.out_valid, 0);
        check("abort radical", bif.radical, 0);
        check("abort ovf", bif.ovf, 0);
        check("abort rem_err", bif.rem_err, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(8'd200, 9'd0);
        checkOutput("after abort", 16'd40000, 1'b0, 1'b0);

        // Sweep every root with a legal remainder.
        for (int q = 0; q < 256; q++) begin
            int r;
            r = int'($urandom_range(2 * q, 0));
            applyStimulus(q[7:0], r[8:0]);
            checkOutput("sweep", 16'(q * q + r), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sqrt_recon_seq.md
Name: sqrt_recon_seq

Overview:
- Inverse of the team's combinational integer square-root unit.
- Takes a (root, remainder) pair and rebuilds the radical as radical = q*q + remainder.
- Uses an iterative shift-add multiplier, one bit per clock, with valid/ready on both sides.
- Sits in the image-match datapath as the round-trip checker: the sqrt output feeds this block, and its result is compared against the original radical.

Parameters:
- Q_WIDTH, 8, width of the root operand q.
- R_WIDTH, 9, width of the remainder operand; must be Q_WIDTH+1.
- WIDTH, 16, width of the reconstructed radical.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- q_in  in  Q_WIDTH  root operand.
- rem_in  in  R_WIDTH  remainder operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- radical  out  WIDTH  q*q + remainder, truncated to WIDTH bits.
- ovf  out  1  full result does not fit in WIDTH bits.
- rem_err  out  1  rem_in > 2*q_in, so the pair is not a legal sqrt output.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, radical=0, ovf=0, rem_err=0, all internal registers 0.
- Internal registers:
  - mcand: 2*Q_WIDTH bits.
  - mplier: Q_WIDTH bits.
  - acc: 2*Q_WIDTH+1 bits.
  - cnt: counts 0..Q_WIDTH-1.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: mcand=q_in zero-extended, mplier=q_in, acc=rem_in zero-extended, cnt=0.
  - rem_err is registered from (rem_in > 2*q_in), evaluated at full precision.
  - Next state is CALC.
- State CALC:
  - in_ready=0, out_valid=0.
  - Each edge: if mplier[0]=1 then acc = acc + mcand; mcand shifts left 1; mplier shifts right 1; cnt increments.
  - On the edge where cnt=Q_WIDTH-1: radical=acc_next[WIDTH-1:0], ovf = OR of acc_next above bit WIDTH-1 (0 if there are no such bits); next state is DONE.
  - Fixed length: always exactly Q_WIDTH cycles, no early exit when mplier becomes zero.
- State DONE:
  - out_valid=1, in_ready=0.
  - radical, ovf and rem_err are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: next state is IDLE, out_valid deasserts.
  - radical, ovf and rem_err keep their last values after the handshake.
- Latency:
  - Operand accepted on edge E.
  - out_valid is high after edge E+Q_WIDTH.
  - The earliest next accept is the edge after the output handshake.
  - Throughput: one result per Q_WIDTH+2 cycles with out_ready tied high.
- No input is accepted in the same cycle as the output handshake; in_ready is purely combinational from state==IDLE.
- Arithmetic:
  - Computed at full 2*Q_WIDTH+1 precision; the maximum (2^Q_WIDTH-1)^2 + 2^(Q_WIDTH+1)-1 cannot wrap the accumulator.
  - Truncation happens only at the output.
- rem_err is informational only; the sum is still computed.
- Reset asserted mid-CALC or in DONE: the operation is aborted immediately, outputs return to reset values, and no result is produced.
- in_valid while busy is ignored and not stored. Upstream must hold in_valid and the operands until in_ready.
- Unknown-state recovery: an illegal state encoding returns to IDLE.

Decomposition:
- Shared package sqrt_pkg:
  - State enum: IDLE, CALC, DONE.
  - Derived constants: ACC_W = 2*Q_WIDTH+1, CNT_W = clog2(Q_WIDTH).
  - The same package is used by the sqrt wrapper and the round-trip checker.
- Optional sub-module shift_add_mul_step: one combinational accumulate/shift step. Otherwise the block stays flat, since the FSM plus datapath is small.

Test Plan:
- Reset, then q_in=0, rem_in=0, out_ready=1 -> out_valid at accept+8 edges, radical=0, ovf=0, rem_err=0; in_ready returns to 1 one edge later.
- q_in=12, rem_in=5 -> radical=149, ovf=0, rem_err=0; in_ready=0 for the whole calculation.
- q_in=255, rem_in=510 -> radical=65535, ovf=0, rem_err=0; q_in=255, rem_in=511 -> radical=0, ovf=1, rem_err=1.
- q_in=3, rem_in=7 -> radical=16, rem_err=1.
- Backpressure: q_in=10, rem_in=4, out_ready held 0 for 5 cycles -> radical=104 held stable with out_valid=1; a second in_valid pulse in that window is not accepted.
- Reset pulse at cycle 3 of CALC with q_in=200 -> all outputs at reset values, in_ready=1. Then q_in=200, rem_in=0 -> radical=40000, no residue from the aborted operation.
- Random sweep: all q_in in 0..255 with rem_in in 0..2q -> every radical equals q*q+r, rem_err=0, ovf=0.
